// File: rtl/cpu_csr_pkg.sv
// Shared CSR addresses, privilege modes, mstatus fields
// and the trap/MRET sequencer state encoding.
package cpu_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [1:0] MODE_MACHINE = 2'd3;
  localparam logic [1:0] MODE_SUPERV  = 2'd1;
  localparam logic [1:0] MODE_USER    = 2'd0;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RDR
  } state_e;

  typedef enum logic {
    OP_TRAP,
    OP_MRET
  } op_e;

endpackage

// File: rtl/mstatus_xform.sv
// mstatus update for trap entry and return;
// purely combinational so SRET can reuse it.
import cpu_csr_pkg::*;

module mstatus_xform (
  input  logic [31:0] mstatus_i,
  input  op_e         op_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] mstatus_o
);

  always_comb begin
    mstatus_o = mstatus_i;
    unique case (op_i)
      OP_TRAP: begin
        mstatus_o[MS_MPIE] = mstatus_i[MS_MIE];
        mstatus_o[MS_MIE]  = 1'b0;
        mstatus_o[MS_MPP_HI:MS_MPP_LO] = mode_i;
      end
      OP_MRET: begin
        mstatus_o[MS_MIE]  = mstatus_i[MS_MPIE];
        mstatus_o[MS_MPIE] = 1'b1;
        mstatus_o[MS_MPP_HI:MS_MPP_LO] = MODE_USER;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trap_csr_sequencer.sv
// Drives trap entry and MRET through the CSR file's
// implicit ports: read, write, then redirect fetch.
import cpu_csr_pkg::*;

module trap_csr_sequencer #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trap_valid,
  input  logic [31:0]   trap_cause,
  input  logic [31:0]   trap_pc,
  input  logic [31:0]   trap_tval,
  input  logic          mret_valid,
  input  logic [1:0]    mode,
  output logic [3:0]    impl_read_enable,
  output logic [47:0]   impl_addrs_r,
  input  logic [127:0]  impl_csr,
  output logic [3:0]    impl_write_enable,
  output logic [47:0]   impl_addrs_w,
  output logic [127:0]  impl_write_data,
  output logic          busy,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic [1:0]    new_mode
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [31:0]   cause_q, cause_d;
  logic [31:0]   tval_q, tval_d;
  logic [31:0]   vec_q, vec_d;
  logic [31:2]   pc_q, pc_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    mpp_q, mpp_d;
  logic [3:0]    rd_en_q, rd_en_d;
  logic [3:0]    wr_en_q, wr_en_d;
  logic [47:0]   rd_addr_q, rd_addr_d;
  logic [47:0]   wr_addr_q, wr_addr_d;
  logic [127:0]  wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          rdv_q, rdv_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [1:0]    nmode_q, nmode_d;
  logic [31:0]   ms_new;
  logic [31:0]   tgt_base;
  logic          vec_hit;
  logic          unused_rd_hi;

  assign unused_rd_hi = ^impl_csr[127:64];

  mstatus_xform u_xform (
    .mstatus_i (impl_csr[31:0]),
    .op_i      (op_q),
    .mode_i    (mode_q),
    .mstatus_o (ms_new)
  );

  assign tgt_base = {vec_q[31:2], 2'b00};
  assign vec_hit  = VECTORED_EN
                 && (vec_q[1:0] == 2'b01)
                 && cause_q[31];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    pc_d      = pc_q;
    mode_d    = mode_q;
    vec_d     = vec_q;
    mpp_d     = mpp_q;
    rd_en_d   = '0;
    rd_addr_d = '0;
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    busy_d    = 1'b0;
    rdv_d     = 1'b0;
    rpc_d     = rpc_q;
    nmode_d   = nmode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trap_valid || mret_valid) begin
          state_d = ST_RD;
          busy_d  = 1'b1;
          mode_d  = mode;
          pc_d    = trap_pc[31:2];
          op_d    = OP_TRAP;
          cause_d = trap_cause;
          tval_d  = trap_tval;
          // MRET below M-mode is an illegal instruction
          if (!trap_valid) begin
            if (mode == MODE_MACHINE) begin
              op_d = OP_MRET;
            end else begin
              cause_d = CAUSE_ILLEGAL_INSN;
              tval_d  = '0;
            end
          end
          rd_en_d   = 4'b0011;
          rd_addr_d = {24'd0,
                       (op_d == OP_MRET) ? CSR_MEPC : CSR_MTVEC,
                       CSR_MSTATUS};
        end
      end
      ST_RD: begin
        state_d = ST_WR;
        busy_d  = 1'b1;
        vec_d   = impl_csr[63:32];
        mpp_d   = impl_csr[MS_MPP_HI:MS_MPP_LO];
        if (op_q == OP_TRAP) begin
          wr_en_d   = 4'b1111;
          wr_addr_d = {CSR_MTVAL, CSR_MCAUSE,
                       CSR_MEPC, CSR_MSTATUS};
          wr_data_d = {tval_q, cause_q,
                       pc_q, 2'b00, ms_new};
        end else begin
          wr_en_d   = 4'b0001;
          wr_addr_d = {36'd0, CSR_MSTATUS};
          wr_data_d = {96'd0, ms_new};
        end
      end
      ST_WR: begin
        state_d = ST_RDR;
        busy_d  = 1'b1;
        rdv_d   = 1'b1;
        if (op_q == OP_TRAP) begin
          rpc_d   = vec_hit
                  ? tgt_base + {cause_q[29:0], 2'b00}
                  : tgt_base;
          nmode_d = MODE_MACHINE;
        end else begin
          rpc_d   = tgt_base;
          nmode_d = (mpp_q == 2'd2) ? MODE_USER : mpp_q;
        end
      end
      ST_RDR: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_TRAP;
      cause_q   <= '0;
      tval_q    <= '0;
      pc_q      <= '0;
      mode_q    <= '0;
      vec_q     <= '0;
      mpp_q     <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      rdv_q     <= 1'b0;
      rpc_q     <= '0;
      nmode_q   <= MODE_MACHINE;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      pc_q      <= pc_d;
      mode_q    <= mode_d;
      vec_q     <= vec_d;
      mpp_q     <= mpp_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      rdv_q     <= rdv_d;
      rpc_q     <= rpc_d;
      nmode_q   <= nmode_d;
    end
  end

  // reset aborts in the same cycle: no write, no redirect
  assign impl_write_enable = wr_en_q & {4{~reset}};
  assign redirect_valid    = rdv_q & ~reset;
  assign impl_read_enable  = rd_en_q;
  assign impl_addrs_r      = rd_addr_q;
  assign impl_addrs_w      = wr_addr_q;
  assign impl_write_data   = wr_data_q;
  assign busy              = busy_q;
  assign redirect_pc       = rpc_q;
  assign new_mode          = nmode_q;

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// Directed bench: a small CSR-file model answers the
// implicit ports; vectors table plus corner sequences.
module tb_trap_csr_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         trap_valid, mret_valid;
  logic [31:0]  trap_cause, trap_pc, trap_tval;
  logic [1:0]   mode;
  logic [3:0]   rd_en, wen;
  logic [47:0]  addrs_r, addrs_w;
  logic [127:0] csr_rd, wdata;
  logic         busy, rdv;
  logic [31:0]  rpc;
  logic [1:0]   nmode;

  logic [3:0]   nv_rd_en, nv_wen;
  logic [47:0]  nv_addrs_r, nv_addrs_w;
  logic [127:0] nv_csr_rd, nv_wdata;
  logic         nv_busy, nv_rdv;
  logic [31:0]  nv_rpc;
  logic [1:0]   nv_nmode;

  logic [31:0] m_mstatus, m_mtvec, m_mepc;
  logic [31:0] m_mcause, m_mtval;
  int rcount = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_csr_sequencer #(.VECTORED_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .mode(mode),
    .impl_read_enable(rd_en), .impl_addrs_r(addrs_r),
    .impl_csr(csr_rd), .impl_write_enable(wen),
    .impl_addrs_w(addrs_w), .impl_write_data(wdata),
    .busy(busy), .redirect_valid(rdv),
    .redirect_pc(rpc), .new_mode(nmode)
  );

  trap_csr_sequencer #(.VECTORED_EN(1'b0)) dut_nv (
    .clk(clk), .reset(reset),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .mode(mode),
    .impl_read_enable(nv_rd_en), .impl_addrs_r(nv_addrs_r),
    .impl_csr(nv_csr_rd), .impl_write_enable(nv_wen),
    .impl_addrs_w(nv_addrs_w), .impl_write_data(nv_wdata),
    .busy(nv_busy), .redirect_valid(nv_rdv),
    .redirect_pc(nv_rpc), .new_mode(nv_nmode)
  );

  function automatic logic [31:0] rd(input logic [11:0] a);
    case (a)
      12'h300: rd = m_mstatus;
      12'h305: rd = m_mtvec;
      12'h341: rd = m_mepc;
      12'h342: rd = m_mcause;
      12'h343: rd = m_mtval;
      default: rd = 32'h0;
    endcase
  endfunction

  always_comb begin
    csr_rd    = '0;
    nv_csr_rd = '0;
    for (int i = 0; i < 4; i++) begin
      csr_rd[32*i +: 32]    = rd(addrs_r[12*i +: 12]);
      nv_csr_rd[32*i +: 32] = rd(nv_addrs_r[12*i +: 12]);
    end
  end

  always @(posedge clk) begin
    if (rdv) rcount = rcount + 1;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        case (addrs_w[12*i +: 12])
          12'h300: m_mstatus = wdata[32*i +: 32];
          12'h341: m_mepc    = wdata[32*i +: 32];
          12'h342: m_mcause  = wdata[32*i +: 32];
          12'h343: m_mtval   = wdata[32*i +: 32];
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic setup(input logic [31:0] ms, tv, ep);
    m_mstatus = ms;
    m_mtvec   = tv;
    m_mepc    = ep;
    m_mcause  = 32'h55;
    m_mtval   = 32'h66;
  endtask

  typedef struct {
    logic        tv, mv;
    logic [1:0]  md;
    logic [31:0] cause, pc, tval;
    logic [31:0] ms, tvec, epc;
    logic [31:0] x_ms, x_epc, x_cause, x_tval;
    logic [3:0]  x_wen;
    logic [31:0] x_rpc, x_rpc_nv;
    logic [1:0]  x_mode;
  } vec_t;

  vec_t vt[9];

  initial begin
    int r0;
    vt[0] = '{1,0,0, 32'h2, 32'h204, 32'hDEADBEEF,
              32'h8, 32'h100, 32'h0,
              32'h80, 32'h204, 32'h2, 32'hDEADBEEF,
              4'hF, 32'h100, 32'h100, 2'd3};
    vt[1] = '{1,0,3, 32'h80000007, 32'h1003, 32'h0,
              32'h8, 32'h101, 32'h0,
              32'h1880, 32'h1000, 32'h80000007, 32'h0,
              4'hF, 32'h11C, 32'h100, 2'd3};
    vt[2] = '{0,1,3, 32'h0, 32'h0, 32'h0,
              32'h880, 32'h100, 32'h400,
              32'h88, 32'h400, 32'h55, 32'h66,
              4'h1, 32'h400, 32'h400, 2'd1};
    vt[3] = '{0,1,0, 32'h77, 32'h300, 32'h99,
              32'h8, 32'h200, 32'h0,
              32'h80, 32'h300, 32'h2, 32'h0,
              4'hF, 32'h200, 32'h200, 2'd3};
    vt[4] = '{1,1,3, 32'h8000000B, 32'h50, 32'h1,
              32'h0, 32'h103, 32'h0,
              32'h1800, 32'h50, 32'h8000000B, 32'h1,
              4'hF, 32'h100, 32'h100, 2'd3};
    vt[5] = '{0,1,3, 32'h0, 32'h0, 32'h0,
              32'h21088, 32'h100, 32'h123,
              32'h20088, 32'h123, 32'h55, 32'h66,
              4'h1, 32'h120, 32'h120, 2'd0};
    vt[6] = '{0,1,3, 32'h0, 32'h0, 32'h0,
              32'h1800, 32'h0, 32'h80000000,
              32'h80, 32'h80000000, 32'h55, 32'h66,
              4'h1, 32'h80000000, 32'h80000000, 2'd3};
    vt[7] = '{1,0,1, 32'h5, 32'h10, 32'h20,
              32'h0, 32'h301, 32'h0,
              32'h800, 32'h10, 32'h5, 32'h20,
              4'hF, 32'h300, 32'h300, 2'd3};
    vt[8] = '{1,0,3, 32'hC0000001, 32'h8, 32'h0,
              32'h8, 32'hFFFFFF01, 32'h0,
              32'h1880, 32'h8, 32'hC0000001, 32'h0,
              4'hF, 32'hFFFFFF04, 32'hFFFFFF00, 2'd3};

    reset = 1'b1;
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    trap_cause = '0;
    trap_pc = '0;
    trap_tval = '0;
    mode = 2'd3;
    setup(32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rdv", rdv, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_wen", wen, 0);
    chk("rst_addr_r", addrs_r, 0);
    chk("rst_addr_w", addrs_w, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_mode", nmode, 3);
    chk("rst_pc", rpc, 0);
    reset = 1'b0;
    tick();

    foreach (vt[k]) begin
      setup(vt[k].ms, vt[k].tvec, vt[k].epc);
      trap_valid = vt[k].tv;
      mret_valid = vt[k].mv;
      mode       = vt[k].md;
      trap_cause = vt[k].cause;
      trap_pc    = vt[k].pc;
      trap_tval  = vt[k].tval;
      tick();
      trap_valid = 1'b0;
      mret_valid = 1'b0;
      chk($sformatf("v%0d_busy_rd", k), busy, 1);
      chk($sformatf("v%0d_rden", k), rd_en, 4'b0011);
      chk($sformatf("v%0d_wen_rd", k), wen, 0);
      tick();
      chk($sformatf("v%0d_wen", k), wen, vt[k].x_wen);
      chk($sformatf("v%0d_rdv_wr", k), rdv, 0);
      tick();
      chk($sformatf("v%0d_rdv", k), rdv, 1);
      chk($sformatf("v%0d_wen_rdr", k), wen, 0);
      chk($sformatf("v%0d_rpc", k), rpc, vt[k].x_rpc);
      chk($sformatf("v%0d_rpc_nv", k), nv_rpc, vt[k].x_rpc_nv);
      chk($sformatf("v%0d_mode", k), nmode, vt[k].x_mode);
      chk($sformatf("v%0d_mstatus", k), m_mstatus, vt[k].x_ms);
      chk($sformatf("v%0d_mepc", k), m_mepc, vt[k].x_epc);
      chk($sformatf("v%0d_mcause", k), m_mcause, vt[k].x_cause);
      chk($sformatf("v%0d_mtval", k), m_mtval, vt[k].x_tval);
      tick();
      chk($sformatf("v%0d_busy_end", k), busy, 0);
      chk($sformatf("v%0d_rdv_end", k), rdv, 0);
    end

    // extra requests while busy are dropped
    setup(32'h8, 32'h100, 32'h0);
    r0 = rcount;
    mode = 2'd0;
    trap_valid = 1'b1;
    trap_cause = 32'h3;
    trap_pc = 32'h40;
    tick();
    trap_cause = 32'h9;
    trap_pc = 32'h80;
    tick();
    tick();
    trap_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("busy_ign_count", rcount - r0, 1);
    chk("busy_ign_cause", m_mcause, 32'h3);
    chk("busy_ign_epc", m_mepc, 32'h40);
    chk("busy_ign_idle", busy, 0);

    // new request accepted in the cycle the FSM is back in IDLE
    setup(32'h0, 32'h100, 32'h0);
    trap_valid = 1'b1;
    trap_cause = 32'h4;
    tick();
    trap_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b_idle", busy, 0);
    trap_valid = 1'b1;
    trap_cause = 32'h6;
    tick();
    trap_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    tick();
    tick();
    tick();
    chk("b2b_cause", m_mcause, 32'h6);

    // reset during the write cycle
    setup(32'h8, 32'h100, 32'h11);
    r0 = rcount;
    trap_valid = 1'b1;
    trap_cause = 32'h2;
    trap_pc = 32'h700;
    trap_tval = 32'h1234;
    tick();
    trap_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rstwr_wen", wen, 0);
    tick();
    chk("rstwr_busy", busy, 0);
    chk("rstwr_rdv", rdv, 0);
    chk("rstwr_ms", m_mstatus, 32'h8);
    chk("rstwr_epc", m_mepc, 32'h11);
    chk("rstwr_cause", m_mcause, 32'h55);
    chk("rstwr_tval", m_mtval, 32'h66);
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("rstwr_busy2", busy, 0);
    chk("rstwr_noredir", rcount - r0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
